// File: rtl/mips_pkg.sv
// mips_pkg: function-code constants and the multiply/divide FSM state type
//   shared by the decoder and the HI/LO multiply/divide unit.
// Ports: none (package).
package mips_pkg;

   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MTHI  = 6'd17;
   localparam logic [5:0] FN_MFLO  = 6'd18;
   localparam logic [5:0] FN_MTLO  = 6'd19;
   localparam logic [5:0] FN_MULT  = 6'd24;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIV   = 6'd26;
   localparam logic [5:0] FN_DIVU  = 6'd27;

   // Iteration counter width: one count per operand bit (32 -> 5 bits).
   localparam int MD_CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } md_state_t;

endpackage

// File: rtl/multdiv_iter.sv
// multdiv_iter: one combinational step of shift-add multiply or restoring divide
//   on a 2*WIDTH accumulator.
// Ports: acc_i (accumulator / {remainder, dividend bits}), operand_i (multiplicand or
//   divisor magnitude), div_mode_i (1 = divide step); acc_o (next accumulator, quotient
//   LSB left 0 in divide mode), qbit_o (quotient bit of this divide step).
module multdiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   operand_i,
   input  logic               div_mode_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic               qbit_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] diff;

   always_comb begin
      // Multiply: add the multiplicand into the upper half when the current
      // multiplier bit (acc LSB) is set, then shift the whole thing right,
      // carry included.
      sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? operand_i : {WIDTH{1'b0}})};
      // Divide: the shifted partial remainder is acc_i[2W-1:W-1] (W+1 bits);
      // the subtraction only matters when it does not borrow, in which case
      // the true difference fits in W bits.
      qbit_o = (acc_i[2*WIDTH-1:WIDTH-1] >= {1'b0, operand_i});
      diff   = acc_i[2*WIDTH-2:WIDTH-1] - operand_i;
      acc_o  = {sum, acc_i[WIDTH-1:1]};
      if (div_mode_i) begin
         if (qbit_o) begin
            acc_o = {diff, acc_i[WIDTH-2:0], 1'b0};
         end else begin
            acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/hilo_multdiv_unit.sv
// hilo_multdiv_unit: iterative MULT/MULTU/DIV/DIVU engine owning architectural HI/LO,
//   plus MTHI/MTLO writes. Optional macro FAST_MULT_EN: single-cycle multiply path.
// Ports: clk, reset (async active-high); start/function_code/op_a/op_b launch an op;
//   hi_wren/lo_wren/wr_data write HI/LO (abort any op in flight); hi/lo are the
//   architectural registers; busy stalls the pipeline; done pulses after commit.
module hilo_multdiv_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       function_code,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hi_wren,
   input  logic             lo_wren,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   md_state_t             state_q, state_d;
   logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0]    acc_q, acc_d, iter_acc;
   logic [WIDTH-1:0]      opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
   logic                  div_q, div_d, sgn_q, sgn_d, nega_q, nega_d, negb_q, negb_d;
   logic                  bz_q, bz_d, done_q, done_d;
   logic                  iter_qbit;

   logic                  op_valid, op_div, op_sgn, mt_wr;
   logic [WIDTH-1:0]      mag_a, mag_b;
   logic [2*WIDTH-1:0]    prod_fix;
   logic [WIDTH-1:0]      quo_fix, rem_fix;

   multdiv_iter #(.WIDTH(WIDTH)) u_iter (
      .acc_i      (acc_q),
      .operand_i  (opb_q),
      .div_mode_i (div_q),
      .acc_o      (iter_acc),
      .qbit_o     (iter_qbit)
   );

   // Operation decode and operand magnitudes (signed ops work on |x|).
   always_comb begin
      op_div   = (function_code == FN_DIV) || (function_code == FN_DIVU);
      op_sgn   = (function_code == FN_MULT) || (function_code == FN_DIV);
      op_valid = op_div || (function_code == FN_MULT) || (function_code == FN_MULTU);
      mag_a    = (op_sgn && op_a[WIDTH-1]) ? -op_a : op_a;
      mag_b    = (op_sgn && op_b[WIDTH-1]) ? -op_b : op_b;
   end

   // Sign correction applied in FINISH. A zero divisor leaves the remainder
   // equal to |op_a|, so restoring the dividend sign yields op_a exactly.
   always_comb begin
      prod_fix = (sgn_q && (nega_q ^ negb_q)) ? -acc_q : acc_q;
      quo_fix  = (sgn_q && (nega_q ^ negb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      if (bz_q) begin
         quo_fix = {WIDTH{1'b1}};
      end
      rem_fix  = (sgn_q && nega_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      div_d   = div_q;
      sgn_d   = sgn_q;
      nega_d  = nega_q;
      negb_d  = negb_q;
      bz_d    = bz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      // The decoder raises hi/lo_wren alongside multdiv; only a bare write counts.
      mt_wr   = !start && (hi_wren || lo_wren);

      if (mt_wr) begin
         if (hi_wren) hi_d = wr_data;
         if (lo_wren) lo_d = wr_data;
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start && op_valid) begin
                  div_d   = op_div;
                  sgn_d   = op_sgn;
                  nega_d  = op_sgn && op_a[WIDTH-1];
                  negb_d  = op_sgn && op_b[WIDTH-1];
                  bz_d    = op_div && (op_b == '0);
                  opb_d   = mag_b;
                  acc_d   = {{WIDTH{1'b0}}, mag_a};
                  cnt_d   = MD_CNT_W'(WIDTH - 1);
                  state_d = RUN;
`ifdef FAST_MULT_EN
                  if (!op_div) begin
                     acc_d   = (2*WIDTH)'(mag_a) * (2*WIDTH)'(mag_b);
                     state_d = FINISH;
                  end
`endif
               end
            end
            RUN: begin
               acc_d = {iter_acc[2*WIDTH-1:1], (div_q ? iter_qbit : iter_acc[0])};
               if (cnt_q == '0) begin
                  state_d = FINISH;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            FINISH: begin
               if (div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         div_q   <= 1'b0;
         sgn_q   <= 1'b0;
         nega_q  <= 1'b0;
         negb_q  <= 1'b0;
         bz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         div_q   <= div_d;
         sgn_q   <= sgn_d;
         nega_q  <= nega_d;
         negb_q  <= negb_d;
         bz_q    <= bz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_hilo_multdiv_unit.sv
module tb_hilo_multdiv_unit;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  function_code;
   logic [31:0] op_a, op_b, wr_data;
   logic        hi_wren, lo_wren;
   logic [31:0] hi, lo;
   logic        busy, done;

   int total = 0;
   int bad   = 0;

   hilo_multdiv_unit #(.WIDTH(32)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .function_code (function_code),
      .op_a          (op_a),
      .op_b          (op_b),
      .hi_wren       (hi_wren),
      .lo_wren       (lo_wren),
      .wr_data       (wr_data),
      .hi            (hi),
      .lo            (lo),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: {hi, lo} straight from the arithmetic definition.
   function automatic logic [63:0] ref_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r, p;
      logic [63:0] ua, ub, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      if (fn == FN_MULT) begin
         p = sa * sb;
         return 64'(p);
      end else if (fn == FN_MULTU) begin
         return ua * ub;
      end else if (b == 32'd0) begin
         return {a, 32'hFFFF_FFFF};
      end else if (fn == FN_DIV) begin
         q = sa / sb;
         r = sa % sb;
         return {r[31:0], q[31:0]};
      end else begin
         uq = ua / ub;
         ur = ua % ub;
         return {ur[31:0], uq[31:0]};
      end
   endfunction

   function automatic int exp_lat(input logic [5:0] fn);
`ifdef FAST_MULT_EN
      if (fn == FN_MULT || fn == FN_MULTU) return 1;
`endif
      return (fn == FN_MULT || fn == FN_MULTU) ? 33 : 33;
   endfunction

   // Launch one op, follow it to done, and check timing, busy and result.
   task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic with_wr);
      logic [63:0] exp;
      logic [31:0] hi0, lo0;
      int          k, busy_n, lat;
      bit          early;
      exp = ref_op(fn, a, b);
      lat = exp_lat(fn);
      hi0 = hi;
      lo0 = lo;
      @(negedge clk);
      start = 1'b1; function_code = fn; op_a = a; op_b = b;
      hi_wren = with_wr; lo_wren = with_wr; wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; hi_wren = 1'b0; lo_wren = 1'b0;
      k = 0; busy_n = 0; early = 1'b0;
      while (!done && k < 100) begin
         if (busy) busy_n++;
         if (hi !== hi0 || lo !== lo0) early = 1'b1;
         @(negedge clk);
         k++;
      end
      check({tag, " latency"}, 64'(k), 64'(lat));
      check({tag, " busy_cycles"}, 64'(busy_n), 64'(lat));
      check({tag, " hilo_held"}, 64'(early), 64'd0);
      check({tag, " result"}, {hi, lo}, exp);
      check({tag, " busy_end"}, 64'(busy), 64'd0);
      @(negedge clk);
      check({tag, " done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      logic [31:0] hi0, lo0, ra, rb;
      logic [5:0]  rfn;
      bit          seen;

      reset = 1'b1; start = 1'b0; function_code = '0; op_a = '0; op_b = '0;
      hi_wren = 1'b0; lo_wren = 1'b0; wr_data = '0;
      #1;
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed arithmetic corners.
      run_op("mult_neg", FN_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
      run_op("multu_max", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op("div_neg7_2", FN_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op("divu_by0", FN_DIVU, 32'd7, 32'd0, 1'b0);
      run_op("div_ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("div_by0_neg", FN_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
      run_op("mult_5x6", FN_MULT, 32'd5, 32'd6, 1'b0);
      run_op("start_with_wr", FN_MULTU, 32'h0001_0000, 32'h0003_0000, 1'b1);

      // Randomized ops against the reference.
      for (int i = 0; i < 12; i++) begin
         rfn = FN_MULT + 6'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 4) == 0) rb = 32'd0;
         else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
         if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
         run_op("random", rfn, ra, rb, 1'b0);
      end

      // Unlisted code on start: nothing happens.
      hi0 = hi; lo0 = lo;
      @(negedge clk);
      start = 1'b1; function_code = FN_MFHI;
      @(negedge clk);
      start = 1'b0;
      check("bad_code busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("bad_code done", 64'(done), 64'd0);
      check("bad_code hilo", {hi, lo}, {hi0, lo0});

      // MTHI while idle.
      hi_wren = 1'b1; wr_data = 32'hCAFE_0001;
      @(negedge clk);
      hi_wren = 1'b0;
      check("mthi_idle hi", 64'(hi), 64'hCAFE_0001);
      check("mthi_idle lo", 64'(lo), 64'(lo0));

      // DIV aborted by MTLO at cycle 10; second start at cycle 5 ignored.
      hi0 = hi;
      start = 1'b1; function_code = FN_DIV; op_a = 32'd100; op_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      start = 1'b1; function_code = FN_MULTU; op_a = 32'd3; op_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      check("abort busy_c6", 64'(busy), 64'd1);
      repeat (4) @(negedge clk);
      lo_wren = 1'b1; wr_data = 32'h0000_1234;
      @(negedge clk);
      lo_wren = 1'b0;
      check("abort lo", 64'(lo), 64'h1234);
      check("abort busy", 64'(busy), 64'd0);
      check("abort hi", 64'(hi), 64'(hi0));
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (done) seen = 1'b1;
         @(negedge clk);
      end
      check("abort no_done", 64'(seen), 64'd0);
      check("abort hilo_kept", {hi, lo}, {hi0, 32'h0000_1234});

      // Reset at cycle 20 of a MULT.
      start = 1'b1; function_code = FN_MULT; op_a = 32'h0001_2345; op_b = 32'h0000_0777;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset hi", 64'(hi), 64'd0);
      check("midreset lo", 64'(lo), 64'd0);
      check("midreset busy", 64'(busy), 64'd0);
      check("midreset done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op("after_reset", FN_DIVU, 32'd1000, 32'd33, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
